// File: rtl/count_seq_pkg.sv
// Shared constants for the count sequencer: state encoding and default sizing.
package count_seq_pkg;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_PRESCALE = 4;

  typedef logic [2:0] state_t;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ABORT = 3'd4;

endpackage

// File: rtl/count_seq_ctrl_if.sv
// Board-control and counter-control bundle between the board, the sequencer and the counter.
interface count_seq_ctrl_if
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic             start;
  logic             stop;
  logic             dir;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_up;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output start, stop, dir, target, q,
    input  cnt_clr, cnt_en, cnt_up, busy, done, aborted
  );

  modport slave (
    input  start, stop, dir, target, q,
    output cnt_clr, cnt_en, cnt_up, busy, done, aborted
  );
endinterface

// File: rtl/count_seq_ctrl_presc_tick.sv
// Modulo-PRESCALE counter with sync clear and enable; tick marks the last count of each period.
module presc_tick
  import count_seq_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? 8'd0 : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// Count sequencer: clears the counter, then paces enables until q reaches the target.
// Optional: COUNT_SEQ_AUTO_RESTART_EN makes DONE loop back to CLEAR until stop.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input logic             sysclk,
  input logic             rstn,
  count_seq_ctrl_if.slave bus
);

  state_t           state;
  state_t           state_nx;
  logic             dir_q;
  logic [WIDTH-1:0] tgt_q;
  logic             tick;
  logic             hit;
  logic             presc_clr;
  logic             presc_en;

  assign hit       = (bus.q == tgt_q);
  assign presc_clr = (state == CLEAR);
  assign presc_en  = (state == RUN);

  presc_tick #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk (sysclk),
    .rst (rstn),
    .clr (presc_clr),
    .en  (presc_en),
    .tick(tick)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start && !bus.stop) state_nx = CLEAR;
      CLEAR:   state_nx = bus.stop ? ABORT : RUN;
      // stop wins over a q match arriving in the same cycle
      RUN: begin
        if (bus.stop)  state_nx = ABORT;
        else if (hit)  state_nx = DONE;
      end
`ifdef COUNT_SEQ_AUTO_RESTART_EN
      DONE:    state_nx = bus.stop ? IDLE : CLEAR;
`else
      DONE:    state_nx = IDLE;
`endif
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rstn) begin
    if (rstn) begin
      state <= IDLE;
      dir_q <= 1'b0;
      tgt_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.start && !bus.stop) begin
        dir_q <= bus.dir;
        tgt_q <= bus.target;
      end
    end
  end

  // Moore outputs decoded from state; only cnt_en looks at live inputs
  assign bus.cnt_clr = (state == CLEAR);
  assign bus.cnt_en  = (state == RUN) && tick && !hit && !bus.stop;
  assign bus.cnt_up  = dir_q;
  assign bus.busy    = (state == CLEAR) || (state == RUN) || (state == DONE);
  assign bus.done    = (state == DONE);
  assign bus.aborted = (state == ABORT);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Self-checking bench for count_seq_ctrl; models the 3-bit counter and predicts timing from step counts.
module tb_count_seq_ctrl;

  localparam int W = 3;
  localparam int P = 4;

  logic sysclk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  count_seq_ctrl_if #(.WIDTH(W)) bus ();

  count_seq_ctrl #(
    .WIDTH   (W),
    .PRESCALE(P)
  ) dut (
    .sysclk(sysclk),
    .rstn  (rstn),
    .bus   (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  // external counter datapath driven by the sequencer
  logic [W-1:0] q_cnt = '0;
  always @(posedge sysclk) begin
    if (bus.cnt_clr)     q_cnt <= '0;
    else if (bus.cnt_en) q_cnt <= bus.cnt_up ? q_cnt + 1'b1 : q_cnt - 1'b1;
  end
  assign bus.q = q_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int steps(input bit d, input int t);
    return d ? t : ((1 << W) - t) % (1 << W);
  endfunction

  task automatic noise_inputs();
    bus.dir    = 1'($urandom);
    bus.target = W'($urandom);
  endtask

  // One start at edge 0; cycle c is the period after edge c.
  task automatic do_run(input bit d, input int t, input string nm);
    int n, dc, laps, last, nclr;
    int en_seen[$];
    int done_seen[$];
    int clr_seen[$];
    int up_bad, busy_bad, abort_early;
    up_bad = 0; busy_bad = 0; abort_early = 0;
    n  = steps(d, t);
    dc = 3 + n * P;
`ifdef COUNT_SEQ_AUTO_RESTART_EN
    laps = 2; last = 2 * dc + 2; nclr = 3;
`else
    laps = 1; last = dc + 1; nclr = 1;
`endif
    @(negedge sysclk);
    bus.start = 1'b1; bus.stop = 1'b0; bus.dir = d; bus.target = W'(t);
    @(posedge sysclk); #1;
    bus.start = 1'b0;
    noise_inputs();
    for (int c = 1; c <= last; c++) begin
      @(negedge sysclk);
      if (bus.cnt_en  === 1'b1) en_seen.push_back(c);
      if (bus.done    === 1'b1) done_seen.push_back(c);
      if (bus.cnt_clr === 1'b1) clr_seen.push_back(c);
      if (bus.cnt_up !== d) up_bad++;
      if (c < last && bus.busy !== 1'b1) busy_bad++;
      if (c < last && bus.aborted !== 1'b0) abort_early++;
      if (c == dc) chk({nm, " q_at_done"}, 32'(q_cnt), t);
      if (c == last) begin
        chk({nm, " busy_end"}, 32'(bus.busy), 0);
`ifdef COUNT_SEQ_AUTO_RESTART_EN
        chk({nm, " aborted_end"}, 32'(bus.aborted), 1);
`else
        chk({nm, " aborted_end"}, 32'(bus.aborted), 0);
`endif
      end
      @(posedge sysclk); #1;
      bus.start = (c + 1 <= dc) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef COUNT_SEQ_AUTO_RESTART_EN
      bus.stop = (c + 1 == 2 * dc + 1);
`endif
      noise_inputs();
    end
    bus.stop = 1'b0;
    chk({nm, " en_count"}, en_seen.size(), n * laps);
    for (int j = 0; j < laps; j++)
      for (int k = 0; k < n; k++)
        if (j * n + k < en_seen.size())
          chk({nm, " en_cycle"}, en_seen[j * n + k], j * dc + 1 + (k + 1) * P);
    chk({nm, " done_count"}, done_seen.size(), laps);
    for (int j = 0; j < laps && j < done_seen.size(); j++)
      chk({nm, " done_cycle"}, done_seen[j], (j + 1) * dc);
    chk({nm, " clr_count"}, clr_seen.size(), nclr);
    for (int j = 0; j < nclr && j < clr_seen.size(); j++)
      chk({nm, " clr_cycle"}, clr_seen[j], j * dc + 1);
    chk({nm, " cnt_up_bad"}, up_bad, 0);
    chk({nm, " busy_bad"}, busy_bad, 0);
    chk({nm, " abort_early"}, abort_early, 0);
  endtask

  // target=5 up, stop held for the cycle after the second enable
  task automatic do_stop_run();
    int en_n, done_n;
    en_n = 0; done_n = 0;
    @(negedge sysclk);
    bus.start = 1'b1; bus.stop = 1'b0; bus.dir = 1'b1; bus.target = W'(5);
    @(posedge sysclk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge sysclk);
      if (bus.cnt_en === 1'b1) en_n++;
      if (bus.done === 1'b1) done_n++;
      if (c == 10) chk("stop cnt_en_blocked", 32'(bus.cnt_en), 0);
      if (c == 11) begin
        chk("stop aborted", 32'(bus.aborted), 1);
        chk("stop busy", 32'(bus.busy), 0);
        chk("stop q_left", 32'(q_cnt), 2);
      end
      @(posedge sysclk); #1;
      bus.stop = (c == 9);
    end
    bus.stop = 1'b0;
    chk("stop en_count", en_n, 2);
    chk("stop done_count", done_n, 0);
  endtask

  initial begin
    rstn = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0; bus.target = '0;
    #1;
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst cnt_clr", 32'(bus.cnt_clr), 0);
    chk("rst cnt_en", 32'(bus.cnt_en), 0);
    chk("rst cnt_up", 32'(bus.cnt_up), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst aborted", 32'(bus.aborted), 0);
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    rstn = 1'b0;

    // start together with stop is refused
    @(negedge sysclk);
    bus.start = 1'b1; bus.stop = 1'b1; bus.dir = 1'b1; bus.target = W'(3);
    @(posedge sysclk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    @(negedge sysclk);
    chk("startstop busy", 32'(bus.busy), 0);
    chk("startstop cnt_clr", 32'(bus.cnt_clr), 0);

    do_run(1'b1, 3, "up3");
    do_run(1'b0, 6, "down6");
    do_run(1'b0, 0, "down0");
    do_run(1'b1, 0, "up0");
    do_stop_run();
    do_run(1'b1, 1, "after_stop");

    // asynchronous reset in the middle of a run
    @(negedge sysclk);
    bus.start = 1'b1; bus.dir = 1'b1; bus.target = W'(7);
    @(posedge sysclk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge sysclk);
    @(negedge sysclk);
    #2;
    rstn = 1'b1;
    #1;
    chk("midrst busy", 32'(bus.busy), 0);
    chk("midrst cnt_up", 32'(bus.cnt_up), 0);
    chk("midrst cnt_clr", 32'(bus.cnt_clr), 0);
    chk("midrst cnt_en", 32'(bus.cnt_en), 0);
    bus.start = 1'b1;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    chk("midrst start_ignored", 32'(bus.busy), 0);
    rstn = 1'b0;
    bus.start = 1'b0;
    @(negedge sysclk);
    chk("midrst post_busy", 32'(bus.busy), 0);
    chk("midrst post_done", 32'(bus.done), 0);
    chk("midrst post_aborted", 32'(bus.aborted), 0);

    for (int i = 0; i < 6; i++)
      do_run(1'($urandom), int'($urandom_range(0, (1 << W) - 1)), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_seq_ctrl.md
Name: count_seq_ctrl

Overview:
- Sequencer for the lab's 3-bit flip-flop counter datapath.
- On a start request it clears the counter, then issues paced count-enable pulses up or down until the counter's Q feedback equals a target, signals done, and returns to idle.
- Sits between board-level controls (buttons/switches) and the counter; owns all counter control lines.

Parameters:
- WIDTH, 3, counter width; width of target and q.
- PRESCALE, 4, sysclk cycles per count step; legal range 1..255.

Ports:
- sysclk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous, active-high reset: 1 = reset asserted.
- start  in  1  level, sampled each edge; accepted only in IDLE.
- stop  in  1  level; aborts CLEAR/RUN.
- dir  in  1  1 = count up, 0 = count down; latched on start acceptance.
- target  in  WIDTH  end value; latched on start acceptance.
- q  in  WIDTH  counter state feedback; changes at the edge after cnt_en/cnt_clr.
- cnt_clr  out  1  synchronous clear to the counter.
- cnt_en  out  1  one-cycle count enable.
- cnt_up  out  1  direction to the counter (latched dir).
- busy  out  1  high in CLEAR, RUN and DONE.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse when stop ends a run.

Behaviour:
- Reset values (async, immediate): state IDLE, presc=0, dir_q=0, tgt_q=0, all outputs 0.
- States: IDLE, CLEAR, RUN, DONE, ABORT. Use Moore outputs, except cnt_en.
- IDLE:
  - start=1 and stop=0 -> CLEAR; latch dir_q<=dir and tgt_q<=target.
  - start=1 and stop=1 -> stay in IDLE.
- CLEAR:
  - Lasts exactly 1 cycle; cnt_clr=1; presc<=0.
  - Next state RUN, or ABORT if stop=1.
- RUN:
  - presc counts 0..PRESCALE-1 and wraps.
  - cnt_en = (presc==PRESCALE-1) && (q!=tgt_q) && !stop.
  - q==tgt_q -> DONE (compare is combinational, so no enable fires that cycle).
  - stop=1 -> ABORT; stop has priority over the q match.
  - start is ignored while in RUN.
- DONE: done=1 for 1 cycle -> IDLE.
- ABORT: aborted=1 for 1 cycle -> IDLE. The counter is left at its current value.
- cnt_up = dir_q in every state; no other output changes with the direction.
- Wrap-around:
  - Counting down from 0 goes to 2^WIDTH-1, and the counter wraps naturally.
  - Each step the controller only checks equality, so every target in 0..2^WIDTH-1 is reachable in either direction.
  - Steps to target: up = target; down = (2^WIDTH - target) mod 2^WIDTH.
- target=0: RUN sees q==0 in its first cycle -> DONE with zero enables issued.
- Latency (start sampled at edge 0):
  - CLEAR in cycle 1, RUN from cycle 2.
  - For N steps, DONE occurs in cycle 2 + N*PRESCALE + 1.
- PRESCALE=1: cnt_en may assert on consecutive cycles.
- rstn mid-run: immediate return to IDLE; outputs drop asynchronously; no done or aborted pulse.

Optional Feature:
- Macro: COUNT_SEQ_AUTO_RESTART_EN.
- Defined: DONE goes to CLEAR, not IDLE. The block re-clears and re-runs with the latched dir_q/tgt_q indefinitely and pulses done each lap; busy stays 1. Only stop (CLEAR/RUN -> ABORT) or reset exits the loop. If stop is high during DONE, the next state is IDLE.
- Undefined: DONE -> IDLE, as described above.

Decomposition:
- Shared package/include count_seq_pkg:
  - State encoding localparams (IDLE=3'd0, CLEAR=3'd1, RUN=3'd2, DONE=3'd3, ABORT=3'd4).
  - Default WIDTH and PRESCALE.
- One natural sub-module: presc_tick.
  - Function: a modulo-PRESCALE counter with sync clear and enable.
  - Output: tick when the count equals PRESCALE-1.
  - Reuse: also serves the board's slow-clock needs.

Test Plan:
- Up run, dir=1, target=3, PRESCALE=4, start pulse at cycle 0:
  - cnt_clr in cycle 1.
  - cnt_en in cycles 5, 9, 13; q=3 in cycle 14.
  - done in cycle 15; busy low in cycle 16.
- Down wrap, dir=0, target=6, WIDTH=3: q goes 0->7->6; exactly 2 cnt_en pulses; cnt_up=0 throughout; then done.
- target=0, either direction: zero cnt_en pulses; done in cycle 3.
- stop asserted in RUN after the 2nd enable with target=5, dir=1:
  - aborted in the next cycle; no done.
  - A new start after that is accepted.
- rstn pulse mid-RUN: outputs drop to 0 immediately without waiting for a clock; state IDLE; start is ignored while rstn=1.
- With COUNT_SEQ_AUTO_RESTART_EN defined, target=2, dir=1:
  - done pulses every 2 + 2*PRESCALE + 1 cycles.
  - stop ends the loop with aborted.
